// File: rtl/morph_stream.sv
// morph_stream: streaming 3x3 binary morphology (pass / erode / dilate / border).
// Two single-bit line buffers feed a sliding window; the result for pixel p is
// registered on the beat that delivers pixel p+IMG_W+1 (real or flushed).
// Optional build macro: MORPH_STATS_EN adds a per-frame count of output ones.
module morph_stream #(
    parameter int IMG_W = 160,
    parameter int IMG_H = 120,
    parameter int CW    = $clog2(IMG_W),
    parameter int RW    = $clog2(IMG_H)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [1:0]    mode,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_pixel,
    input  logic          in_sof,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_pixel,
    output logic          out_sof,
    output logic          out_eof,
    output logic          busy,
    output logic          sync_err,
    output logic [RW+CW:0] ones_count
);

    localparam logic [CW-1:0] COL_LAST    = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST    = RW'(IMG_H - 1);
    localparam logic [RW:0]   IN_ROW_LAST = (RW+1)'(IMG_H - 1);
    localparam logic [RW:0]   IN_ROW_ONE  = (RW+1)'(1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t        state_reg, state_next;
    logic [1:0]    mode_reg;
    logic [CW-1:0] in_col_reg;     // column of the next input beat
    logic [RW:0]   in_row_reg;     // row of the next input beat (runs into the flush rows)
    logic          primed_reg;     // window holds enough rows to produce output
    logic [CW-1:0] pc_reg;         // column of the next output pixel
    logic [RW-1:0] pr_reg;         // row of the next output pixel
    logic [2:0]    wl_reg, wc_reg; // left and centre window columns, bit2 = top row
    logic          out_valid_reg, out_pixel_reg, out_sof_reg, out_eof_reg;
    logic          sync_err_reg;

    logic lb_a [0:IMG_W-1];        // previous row
    logic lb_b [0:IMG_W-1];        // row before that

    logic          adv, in_ready_c, virt_beat, accept;
    logic          sof_start, run_beat, idle_drop, abandon, beat, emit;
    logic          in_last, out_last;
    logic [CW-1:0] beat_col;
    logic          beat_pix;
    logic [2:0]    new_col;
    logic [2:0]    row_ok;
    logic          left_ok, right_ok;
    logic [8:0]    taps, tap_ok;
    logic          ero, dil, centre, result;

    assign adv      = !out_valid_reg || out_ready;
    assign in_last  = (in_row_reg == IN_ROW_LAST) && (in_col_reg == COL_LAST);
    assign out_last = (pr_reg == ROW_LAST) && (pc_reg == COL_LAST);

    // Next-state and handshake decode
    always_comb begin
        state_next = state_reg;
        in_ready_c = 1'b0;
        virt_beat  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready_c = 1'b1;
                if (in_valid && in_sof)
                    state_next = RUN;
            end
            RUN: begin
                in_ready_c = adv;
                if (in_valid && adv && !in_sof && in_last)
                    state_next = FLUSH;
            end
            FLUSH: begin
                virt_beat = adv;
                if (adv && out_last)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = in_ready_c;
    assign accept    = in_valid && in_ready_c;
    assign sof_start = accept && in_sof;
    assign idle_drop = accept && !in_sof && (state_reg == IDLE);
    assign abandon   = accept && in_sof && (state_reg == RUN);
    assign run_beat  = accept && !in_sof && (state_reg == RUN);
    assign beat      = sof_start || run_beat || virt_beat;
    assign emit      = (run_beat || virt_beat) && primed_reg;

    // Incoming window column: two rows from the line buffers plus the new pixel
    assign beat_col = sof_start ? '0 : in_col_reg;
    assign beat_pix = virt_beat ? 1'b0 : in_pixel;
    assign new_col  = {lb_b[beat_col], lb_a[beat_col], beat_pix};

    // Edge masks: taps outside the image are excluded so no row-wrap mixing occurs
    assign row_ok   = {pr_reg != '0, 1'b1, pr_reg != ROW_LAST};
    assign left_ok  = (pc_reg != '0);
    assign right_ok = (pc_reg != COL_LAST);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_taps
            assign taps[gi]       = wl_reg[gi];
            assign taps[3 + gi]   = wc_reg[gi];
            assign taps[6 + gi]   = new_col[gi];
            assign tap_ok[gi]     = row_ok[gi] && left_ok;
            assign tap_ok[3 + gi] = row_ok[gi];
            assign tap_ok[6 + gi] = row_ok[gi] && right_ok;
        end
    endgenerate

    assign ero    = &(taps | ~tap_ok);
    assign dil    = |(taps & tap_ok);
    assign centre = wc_reg[1];

    // Operator select on the frame's latched mode
    always_comb begin
        case (mode_reg)
            2'b00:   result = centre;
            2'b01:   result = ero;
            2'b10:   result = dil;
            default: result = centre && !ero;
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Line buffers: contents need no reset, masks hide stale data
    always_ff @(posedge clock) begin
        if (beat) begin
            lb_b[beat_col] <= lb_a[beat_col];
            lb_a[beat_col] <= beat_pix;
        end
    end

    // Position counters, window shift and mode latch
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_reg   <= 2'b00;
            in_col_reg <= '0;
            in_row_reg <= '0;
            primed_reg <= 1'b0;
            pc_reg     <= '0;
            pr_reg     <= '0;
            wl_reg     <= '0;
            wc_reg     <= '0;
        end else if (beat) begin
            wl_reg <= wc_reg;
            wc_reg <= new_col;
            if (sof_start) begin
                mode_reg   <= mode;
                in_col_reg <= CW'(1);
                in_row_reg <= '0;
                primed_reg <= 1'b0;
                pc_reg     <= '0;
                pr_reg     <= '0;
            end else begin
                if (in_col_reg == COL_LAST) begin
                    in_col_reg <= '0;
                    in_row_reg <= in_row_reg + 1'b1;
                end else begin
                    in_col_reg <= in_col_reg + 1'b1;
                end
                if (in_row_reg == IN_ROW_ONE && in_col_reg == '0)
                    primed_reg <= 1'b1;
                if (primed_reg) begin
                    if (pc_reg == COL_LAST) begin
                        pc_reg <= '0;
                        pr_reg <= (pr_reg == ROW_LAST) ? '0 : pr_reg + 1'b1;
                    end else begin
                        pc_reg <= pc_reg + 1'b1;
                    end
                end
            end
        end
    end

    // Output register: load on emission, drop on abandon, hold while stalled
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            out_pixel_reg <= 1'b0;
            out_sof_reg   <= 1'b0;
            out_eof_reg   <= 1'b0;
            sync_err_reg  <= 1'b0;
        end else begin
            sync_err_reg <= idle_drop || abandon;
            if (emit) begin
                out_valid_reg <= 1'b1;
                out_pixel_reg <= result;
                out_sof_reg   <= (pc_reg == '0) && (pr_reg == '0);
                out_eof_reg   <= out_last;
            end else if (abandon) begin
                out_valid_reg <= 1'b0;
                out_sof_reg   <= 1'b0;
                out_eof_reg   <= 1'b0;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_pixel = out_pixel_reg;
    assign out_sof   = out_sof_reg;
    assign out_eof   = out_eof_reg;
    assign busy      = (state_reg != IDLE);
    assign sync_err  = sync_err_reg;

`ifdef MORPH_STATS_EN
    logic [RW+CW:0] ones_acc_reg, ones_count_reg, ones_base, ones_sum;
    logic           out_done;

    assign out_done = out_valid_reg && out_ready;

    // Running total restarts at the frame's first output pixel
    always_comb begin
        ones_base = out_sof_reg ? '0 : ones_acc_reg;
        ones_sum  = ones_base + (RW+CW+1)'(out_pixel_reg);
    end

    // Accumulate completed output ones; publish the total after the last pixel
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ones_acc_reg   <= '0;
            ones_count_reg <= '0;
        end else if (out_done) begin
            ones_acc_reg <= ones_sum;
            if (out_eof_reg)
                ones_count_reg <= ones_sum;
        end
    end

    assign ones_count = ones_count_reg;
`else
    assign ones_count = '0;
`endif

endmodule

// File: tb/tb_morph_stream.sv
// Directed bench for morph_stream on an 8x6 image: table of whole frames with
// hand-computed result images, plus sequences for stalls, sync errors and reset.
module tb_morph_stream;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int N  = W * H;
    localparam int CW = $clog2(W);
    localparam int RW = $clog2(H);

    logic clock = 1'b0;
    logic reset;
    logic [1:0] mode;
    logic in_valid, in_ready, in_pixel, in_sof;
    logic out_valid, out_ready, out_pixel, out_sof, out_eof;
    logic busy, sync_err;
    logic [RW+CW:0] ones_count;

    always #5 clock = ~clock;

    morph_stream #(.IMG_W(W), .IMG_H(H)) dut (
        .clock(clock), .reset(reset), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel), .in_sof(in_sof),
        .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
        .out_sof(out_sof), .out_eof(out_eof), .busy(busy), .sync_err(sync_err),
        .ones_count(ones_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Collector: samples handshakes on the falling edge, restarts at each out_sof
    logic [N-1:0] got_img = '0;
    int got_n = 0, sof_pos = -1, eof_pos = -1;
    int eof_cnt = 0, err_cnt = 0, acc_count = 0, first_acc = -1;

    always @(negedge clock) begin
        if (!reset) begin
            if (sync_err) err_cnt++;
            if (out_valid && first_acc < 0) first_acc = acc_count;
            if (out_valid && out_ready) begin
                if (out_sof) begin
                    got_n = 0; got_img = '0; sof_pos = -1; eof_pos = -1;
                end
                if (got_n < N) got_img[got_n] = out_pixel;
                if (out_sof) sof_pos = got_n;
                if (out_eof) begin eof_pos = got_n; eof_cnt++; end
                got_n++;
            end
            if (in_valid && in_ready) begin
                if (in_sof) begin acc_count = 0; first_acc = -1; end
                acc_count++;
            end
        end
    end

    // Send nbeats pixels of img (SOF on the first), optional 5-cycle output stall,
    // then count flush cycles with in_ready low.
    task automatic send_frame(input logic [1:0] m, input logic [N-1:0] img,
                              input int nbeats, input int stall_at, output int flush_low);
        int i = 0;
        int guard = 0;
        bit stalled = 0;
        logic held;
        mode = m;
        while (i < nbeats && guard < 2000) begin
            @(posedge clock); #1;
            in_valid = 1'b1;
            in_pixel = img[i];
            in_sof   = (i == 0);
            if (i == 1) mode = ~m;
            if (i == stall_at && !stalled) begin
                stalled = 1;
                out_ready = 1'b0;
                @(negedge clock);
                held = out_pixel;
                for (int k = 0; k < 5; k++) begin
                    if (k > 0) @(negedge clock);
                    chk("stall_valid", out_valid, 1);
                    chk("stall_pixel", out_pixel, held);
                    chk("stall_in_ready", in_ready, 0);
                end
                @(posedge clock); #1;
                out_ready = 1'b1;
            end
            @(negedge clock);
            if (in_ready) i++;
            guard++;
        end
        if (i < nbeats) chk("send_timeout", i, nbeats);
        @(posedge clock); #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        flush_low = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (in_ready) break;
            flush_low++;
        end
    endtask

    task automatic wait_eof(input int e0);
        int k = 0;
        while (eof_cnt == e0 && k < 300) begin
            @(negedge clock);
            k++;
        end
        if (eof_cnt == e0) chk("eof_timeout", 0, 1);
        @(posedge clock); @(posedge clock); #1;
    endtask

    task automatic chk_ones(input int exp);
`ifdef MORPH_STATS_EN
        chk("ones_count", ones_count, exp);
`else
        chk("ones_count", ones_count, 0);
`endif
    endtask

    typedef struct {
        logic [1:0]  m;
        logic [47:0] img;
        logic [47:0] exp;
        int          stall;
        int          ones;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int fl, e0, r0;
        // bit index = row*8 + col, so each hex byte is one row (row 0 rightmost)
        tbl[0] = '{2'b00, 48'hAAAA_AAAA_AAAA, 48'hAAAA_AAAA_AAAA, -1, 24};
        tbl[1] = '{2'b00, 48'hAAAA_AAAA_AAAA, 48'hAAAA_AAAA_AAAA, 20, 24};
        tbl[2] = '{2'b01, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, -1, 48};
        tbl[3] = '{2'b10, 48'h0000_0008_0000, 48'h0000_1C1C_1C00, -1, 9};
        tbl[4] = '{2'b11, 48'h0000_0E0E_0E00, 48'h0000_0E0A_0E00, -1, 8};
        tbl[5] = '{2'b01, 48'h0000_0E0E_0E00, 48'h0000_0004_0000, -1, 1};
        tbl[6] = '{2'b10, 48'h0000_0000_0001, 48'h0000_0000_0303, -1, 4};
        tbl[7] = '{2'b10, 48'h0000_0000_8000, 48'h0000_00C0_C0C0, -1, 6};

        reset = 1'b1; mode = 2'b00;
        in_valid = 1'b0; in_pixel = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clock); #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sync_err", sync_err, 0);
        chk("rst_out_pixel", out_pixel, 0);
        chk("rst_ones", ones_count, 0);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_in_ready", in_ready, 1);

        for (int t = 0; t < 8; t++) begin
            e0 = eof_cnt;
            send_frame(tbl[t].m, tbl[t].img, N, tbl[t].stall, fl);
            wait_eof(e0);
            chk("image", got_img, tbl[t].exp);
            chk("out_count", got_n, N);
            chk("sof_pos", sof_pos, 0);
            chk("eof_pos", eof_pos, N - 1);
            chk("latency_beats", first_acc, W + 2);
            chk("flush_cycles", fl, W + 1);
            chk("idle_busy", busy, 0);
            chk_ones(tbl[t].ones);
            $display("frame %0d mode=%0d stall=%0d out=%h", t, tbl[t].m, tbl[t].stall, got_img);
        end

        // SOF arriving at index 20: old frame dropped, new frame (new mode) runs clean
        r0 = err_cnt;
        send_frame(2'b01, tbl[4].img, 20, -1, fl);
        e0 = eof_cnt;
        send_frame(tbl[3].m, tbl[3].img, N, -1, fl);
        wait_eof(e0);
        chk("sof_err_pulse", err_cnt - r0, 1);
        chk("sof_err_image", got_img, tbl[3].exp);
        chk("sof_err_count", got_n, N);
        chk_ones(9);
        $display("frame sof_err out=%h errs=%0d", got_img, err_cnt - r0);

        // Non-SOF beat while idle is dropped with a single error pulse
        r0 = err_cnt;
        @(posedge clock); #1;
        in_valid = 1'b1; in_sof = 1'b0; in_pixel = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clock); #1;
        chk("idle_err_pulse", err_cnt - r0, 1);
        chk("idle_busy", busy, 0);
        chk("idle_out_valid", out_valid, 0);
        $display("idle drop errs=%0d", err_cnt - r0);

        // Asynchronous reset while streaming with an output pending
        @(posedge clock); #1;
        mode = 2'b00; in_valid = 1'b1; in_sof = 1'b1; in_pixel = 1'b1;
        @(posedge clock); #1;
        in_sof = 1'b0;
        repeat (14) @(posedge clock);
        #2;
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_valid", out_valid, 1);
        reset = 1'b1;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_busy", busy, 0);
        in_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_busy", busy, 0);
        $display("reset mid-frame done");

        // Recovery frame after reset
        e0 = eof_cnt;
        send_frame(tbl[4].m, tbl[4].img, N, -1, fl);
        wait_eof(e0);
        chk("recover_image", got_img, tbl[4].exp);
        chk("recover_count", got_n, N);
        chk_ones(8);
        $display("frame recover out=%h", got_img);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/morph_stream.md
Name: morph_stream

Overview:
- Parametrised streaming 3x3 binary morphology engine: erosion, dilation, pass-through and border extraction on a raster pixel stream.
- Successor to the fixed per-address processing stages feeding the VGA path. Generalised in image size, has in/out valid-ready handshakes and internal line buffers.
- Sits between the image ROM/frame source and the display mux. Several instances may be chained.

Parameters:
- IMG_W, 160, pixels per row (>=3)
- IMG_H, 120, rows per frame (>=3)
- CW, $clog2(IMG_W), column counter width
- RW, $clog2(IMG_H), row counter width

Ports:
- clock  input  1  single clock
- reset  input  1  asynchronous, active-high
- mode  input  2  00 pass, 01 erode, 10 dilate, 11 border; sampled on accepted SOF beat
- in_valid  input  1  input pixel valid
- in_ready  output  1  engine accepts input this cycle
- in_pixel  input  1  binary pixel
- in_sof  input  1  marks pixel (0,0)
- out_valid  output  1  output pixel valid
- out_ready  input  1  sink accepts output
- out_pixel  output  1  processed pixel
- out_sof  output  1  with output pixel (0,0)
- out_eof  output  1  with output pixel (IMG_H-1,IMG_W-1)
- busy  output  1  frame in progress (state != IDLE)
- sync_err  output  1  one-cycle pulse on protocol error
- ones_count  output  RW+CW+1  see Optional Feature

Behaviour:
- Reset (async, any time, including mid-frame):
  - state=IDLE; out_valid, out_sof, out_eof, sync_err, busy = 0; out_pixel=0; ones_count=0.
  - Counters cleared; line buffer contents don't-care.
- Transfer rules:
  - Input beat accepted when in_valid & in_ready.
  - Output beat completes when out_valid & out_ready.
  - While out_valid & !out_ready: out_pixel/out_sof/out_eof held stable, nothing advances.
- FSM:
  - IDLE: in_ready=1.
    - Accepted beat with in_sof=1: latch mode, store pixel as index 0, go to RUN.
    - Accepted beat with in_sof=0: discarded, sync_err pulses.
  - RUN: in_ready = !out_valid | out_ready.
    - Accepts indices 1..IMG_W*IMG_H-1.
    - After the last index is accepted, go to FLUSH.
    - Accepted in_sof=1 at any index !=0: sync_err pulses, current frame abandoned (out_valid cleared, pending outputs dropped), that beat taken as index 0 of a new frame, mode relatched.
  - FLUSH: in_ready=0.
    - Injects IMG_W+1 virtual input beats, one per cycle when output is not stalled.
    - After the beat that produces out_eof completes, go to IDLE.
- Buffering: two IMG_W-deep 1-bit line buffers plus a 3x3 window register.
- Latency: output pixel p (raster index) is registered on the clock edge that accepts input index p+IMG_W+1, real or virtual. out_valid is high the following cycle.
- Window outside the image (row -1/IMG_H, col -1/IMG_W) is neutral, so output size equals input size:
  - erode: out-of-image taps read 1; result is AND of 9 taps.
  - dilate: out-of-image taps read 0; result is OR of 9 taps.
  - pass: out = centre tap.
  - border: out = centre & ~erode(window).
- Column wrap at IMG_W-1 increments row. The window must never mix pixels across the row boundary (edge masks apply).
- out_sof on output index 0; out_eof on index IMG_W*IMG_H-1. Both are qualified by out_valid.
- Mode changes outside an accepted SOF beat have no effect on the frame in flight.

Optional Feature:
- Macro MORPH_STATS_EN.
- Defined:
  - Internal counter of accepted output beats with out_pixel=1, cleared at each out_sof beat.
  - ones_count updated with the final total on the cycle after the out_eof beat completes; holds until the next update.
  - Frame abandoned by SOF error: ones_count not updated.
- Undefined: counter not built, ones_count tied to 0.

Test Plan:
- Use IMG_W=8, IMG_H=6 unless noted.
- Reset:
  - Stimulus: assert reset mid-RUN.
  - Required: same cycle out_valid=0, busy=0; after release in_ready=1, state IDLE.
- Pass, 48-beat frame, pixel = index bit 0, out_ready=1:
  - First out_valid the cycle after the 10th accepted beat.
  - 48 outputs equal the input, out_sof on the first, out_eof on the 48th.
  - in_ready=0 for exactly 9 flush cycles.
- Erode, all-ones frame: all 48 outputs 1.
- Dilate, single 1 at (2,3): exactly 9 ones, at rows 1-3, cols 2-4. With MORPH_STATS_EN, ones_count=9.
- Border, 3x3 block of ones at rows 1-3, cols 1-3: ring of 8 ones, (2,2)=0, all else 0.
- Backpressure:
  - out_ready low 5 cycles mid-frame: out_valid held, out_pixel stable, in_ready=0.
  - Output sequence identical to the no-stall run.
- Sync errors:
  - in_sof on index 20: sync_err one pulse, new frame processed correctly, 48 outputs.
  - Non-SOF beat in IDLE: sync_err pulse, beat dropped.
